// File: rtl/nn_ctrl.sv
// rtl/nn_ctrl.sv - two-layer neural network inference sequencer
// Steps the hidden MACs over the input SRAM, then the output MAC over hidden x output weights.
module nn_ctrl #(
    parameter int N_IN    = 784,
    parameter int N_HID   = 10,
    parameter int N_OUT   = 10,
    parameter int DRAIN   = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mac1_done,
    input  logic        sig_ready,
    output logic [17:0] address_1,
    output logic [11:0] address_2,
    output logic [9:0]  address_3,
    output logic [6:0]  address_6,
    output logic [6:0]  sel,
    output logic        mac1_start,
    output logic        mac2_start,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int HW = (N_HID > 1) ? $clog2(N_HID) : 1;
    localparam int OW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int KW = (N_OUT * N_HID > 1) ? $clog2(N_OUT * N_HID) : 1;
    localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        L1_RUN   = 3'd1,
        L1_WAIT  = 3'd2,
        SIG_WAIT = 3'd3,
        L2_RUN   = 3'd4,
        L2_DRAIN = 3'd5,
        FIN      = 3'd6,
        ERR      = 3'd7
    } state_t;

    state_t        state, state_n;
    logic [IW-1:0] i_cnt, i_n;
    logic [HW-1:0] h_cnt, h_n;
    logic [OW-1:0] o_cnt, o_n;
    logic [KW-1:0] k_cnt, k_n;
    logic [DW-1:0] d_cnt, d_n;
    logic [WW-1:0] w_cnt, w_n;

    logic [17:0] address_1_n;
    logic [11:0] address_2_n;
    logic [9:0]  address_3_n;
    logic [6:0]  address_6_n;
    logic [6:0]  sel_n;
    logic        mac1_start_n, mac2_start_n, busy_n, done_n, err_n;

    always_comb begin
        state_n = state;
        i_n     = i_cnt;
        h_n     = h_cnt;
        o_n     = o_cnt;
        k_n     = k_cnt;
        d_n     = d_cnt;
        w_n     = w_cnt;
        unique case (state)
            IDLE, ERR: begin
                if (start) begin
                    state_n = L1_RUN;
                    i_n     = '0;
                end
            end
            L1_RUN: begin
                if (i_cnt == IW'(N_IN - 1)) begin
                    state_n = L1_WAIT;
                    i_n     = '0;
                    w_n     = '0;
                end else begin
                    i_n = i_cnt + IW'(1);
                end
            end
            L1_WAIT: begin
                if (mac1_done) begin
                    state_n = SIG_WAIT;
                    w_n     = '0;
                end else if (w_cnt == WW'(TIMEOUT - 1)) begin
                    state_n = ERR;
                    w_n     = '0;
                end else begin
                    w_n = w_cnt + WW'(1);
                end
            end
            SIG_WAIT: begin
                if (sig_ready) begin
                    state_n = L2_RUN;
                    w_n     = '0;
                    h_n     = '0;
                    o_n     = '0;
                    k_n     = '0;
                end else if (w_cnt == WW'(TIMEOUT - 1)) begin
                    state_n = ERR;
                    w_n     = '0;
                end else begin
                    w_n = w_cnt + WW'(1);
                end
            end
            L2_RUN: begin
                // k tracks o*N_HID+h directly so no multiplier is needed
                k_n = k_cnt + KW'(1);
                if (h_cnt == HW'(N_HID - 1)) begin
                    h_n = '0;
                    if (o_cnt == OW'(N_OUT - 1)) begin
                        state_n = L2_DRAIN;
                        o_n     = '0;
                        k_n     = '0;
                        d_n     = '0;
                    end else begin
                        o_n = o_cnt + OW'(1);
                    end
                end else begin
                    h_n = h_cnt + HW'(1);
                end
            end
            L2_DRAIN: begin
                if (d_cnt == DW'(DRAIN - 1)) begin
                    state_n = FIN;
                    d_n     = '0;
                end else begin
                    d_n = d_cnt + DW'(1);
                end
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Outputs are decoded from the next state so the registers line up with it
        mac1_start_n = (state_n == L1_RUN);
        mac2_start_n = (state_n == L2_RUN);
        address_1_n  = mac1_start_n ? 18'(i_n) : '0;
        address_3_n  = mac1_start_n ? 10'(i_n) : '0;
        address_2_n  = mac2_start_n ? 12'(k_n) : '0;
        sel_n        = mac2_start_n ? 7'(h_n) : '0;
        address_6_n  = mac2_start_n ? 7'(o_n) : '0;
        busy_n       = (state_n inside {L1_RUN, L1_WAIT, SIG_WAIT, L2_RUN, L2_DRAIN});
        done_n       = (state_n == FIN);
        err_n        = (state_n == ERR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            i_cnt      <= '0;
            h_cnt      <= '0;
            o_cnt      <= '0;
            k_cnt      <= '0;
            d_cnt      <= '0;
            w_cnt      <= '0;
            address_1  <= '0;
            address_2  <= '0;
            address_3  <= '0;
            address_6  <= '0;
            sel        <= '0;
            mac1_start <= 1'b0;
            mac2_start <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            i_cnt      <= i_n;
            h_cnt      <= h_n;
            o_cnt      <= o_n;
            k_cnt      <= k_n;
            d_cnt      <= d_n;
            w_cnt      <= w_n;
            address_1  <= address_1_n;
            address_2  <= address_2_n;
            address_3  <= address_3_n;
            address_6  <= address_6_n;
            sel        <= sel_n;
            mac1_start <= mac1_start_n;
            mac2_start <= mac2_start_n;
            busy       <= busy_n;
            done       <= done_n;
            err        <= err_n;
        end
    end
endmodule

// File: tb/tb_nn_ctrl.sv
// tb/tb_nn_ctrl.sv - directed self-checking bench for nn_ctrl
// Instance a uses a small network with a short timeout; instance b uses the defaults.
module tb_nn_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    logic start = 1'b0, mac1_done = 1'b0, sig_ready = 1'b0;
    logic b_start = 1'b0, b_mac1_done = 1'b0, b_sig_ready = 1'b0;

    logic [17:0] a_address_1, b_address_1;
    logic [11:0] a_address_2, b_address_2;
    logic [9:0]  a_address_3, b_address_3;
    logic [6:0]  a_address_6, b_address_6, a_sel, b_sel;
    logic a_mac1_start, a_mac2_start, a_busy, a_done, a_err;
    logic b_mac1_start, b_mac2_start, b_busy, b_done, b_err;

    int errors = 0;
    int checks = 0;

    nn_ctrl #(.N_IN(4), .N_HID(3), .N_OUT(2), .DRAIN(2), .TIMEOUT(5)) dut_a (
        .clk(clk), .reset(reset), .start(start), .mac1_done(mac1_done), .sig_ready(sig_ready),
        .address_1(a_address_1), .address_2(a_address_2), .address_3(a_address_3),
        .address_6(a_address_6), .sel(a_sel), .mac1_start(a_mac1_start),
        .mac2_start(a_mac2_start), .busy(a_busy), .done(a_done), .err(a_err)
    );

    nn_ctrl dut_b (
        .clk(clk), .reset(reset), .start(b_start), .mac1_done(b_mac1_done), .sig_ready(b_sig_ready),
        .address_1(b_address_1), .address_2(b_address_2), .address_3(b_address_3),
        .address_6(b_address_6), .sel(b_sel), .mac1_start(b_mac1_start),
        .mac2_start(b_mac2_start), .busy(b_busy), .done(b_done), .err(b_err)
    );

    wire [58:0] a_obs = {a_mac1_start, a_address_3, a_address_1, a_mac2_start, a_address_2,
                         a_sel, a_address_6, a_busy, a_done, a_err};
    wire [58:0] b_obs = {b_mac1_start, b_address_3, b_address_1, b_mac2_start, b_address_2,
                         b_sel, b_address_6, b_busy, b_done, b_err};

    task automatic cleanup;
        reset = 1'b1;
        start = 1'b0; mac1_done = 1'b0; sig_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b1; b_start = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (a_obs !== 59'd0) begin errors++; $display("FAIL reset_a obs=%h exp=0", a_obs); end
        checks++; if (b_obs !== 59'd0) begin errors++; $display("FAIL reset_b obs=%h exp=0", b_obs); end
        reset = 1'b0; start = 1'b0; b_start = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (a_obs !== 59'd0) begin errors++; $display("FAIL idle_hold obs=%h exp=0", a_obs); end
    endtask

    task automatic test_inference(input bit restart_in_l2, input string name);
        int done_cnt = 0;
        start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            bit m1, m2, bz, dn;
            int a3, k;
            logic [58:0] exp_v;
            @(negedge clk);
            m1 = (c >= 1 && c <= 4);
            m2 = (c >= 9 && c <= 14);
            bz = (c >= 1 && c <= 16);
            dn = (c == 17);
            a3 = m1 ? c - 1 : 0;
            k  = m2 ? c - 9 : 0;
            exp_v = {m1, 10'(a3), 18'(a3), m2, 12'(k), 7'(k % 3), 7'(k / 3), bz, dn, 1'b0};
            checks++;
            if (a_obs !== exp_v) begin
                errors++;
                $display("FAIL %s cycle=%0d obs=%h exp=%h", name, c, a_obs, exp_v);
            end
            if (a_done) done_cnt++;
            start     = restart_in_l2 && (c == 10);
            mac1_done = (c == 6);
            sig_ready = (c == 8);
        end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL %s_done_count got=%0d exp=1", name, done_cnt); end
    endtask

    task automatic test_reset_mid_run;
        start = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if ({a_mac1_start, a_address_3} !== {1'b1, 10'(c - 1)}) begin
                errors++; $display("FAIL midrst_l1 cycle=%0d addr3=%0d exp=%0d", c, a_address_3, c - 1);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (a_obs !== 59'd0) begin errors++; $display("FAIL midrst_zero obs=%h exp=0", a_obs); end
        repeat (2) @(negedge clk);
        checks++; if (a_obs !== 59'd0) begin errors++; $display("FAIL midrst_idle obs=%h exp=0", a_obs); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({a_mac1_start, a_address_3, a_busy} !== {1'b1, 10'd0, 1'b1}) begin
            errors++; $display("FAIL midrst_restart m1=%b addr3=%0d busy=%b exp 1,0,1",
                               a_mac1_start, a_address_3, a_busy);
        end
        cleanup();
    endtask

    task automatic test_timeout;
        start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if ({a_busy, a_err, a_mac2_start, a_mac1_start} !== {c <= 9, c >= 10, 1'b0, c <= 4}) begin
                errors++; $display("FAIL timeout cycle=%0d busy=%b err=%b m2=%b m1=%b",
                                   c, a_busy, a_err, a_mac2_start, a_mac1_start);
            end
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({a_err, a_busy, a_mac1_start, a_address_3} !== {1'b0, 1'b1, 1'b1, 10'd0}) begin
            errors++; $display("FAIL err_clear err=%b busy=%b m1=%b addr3=%0d exp 0,1,1,0",
                               a_err, a_busy, a_mac1_start, a_address_3);
        end
        cleanup();
    endtask

    task automatic test_spurious_done;
        start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if ({a_mac2_start, a_busy, a_err} !== {c >= 10, 1'b1, 1'b0}) begin
                errors++; $display("FAIL spurious cycle=%0d m2=%b busy=%b err=%b exp m2=%b",
                                   c, a_mac2_start, a_busy, a_err, c >= 10);
            end
            mac1_done = (c == 2) || (c == 8);
            sig_ready = (c >= 5 && c <= 9);
        end
        cleanup();
    endtask

    task automatic test_defaults;
        int last_a3 = -1, last_a1 = -1, last_a2 = -1, last_sel = -1, last_a6 = -1;
        int busy_cnt = 0, m1_cnt = 0, m2_cnt = 0, done_cycle = -1;
        b_start = 1'b1;
        for (int c = 1; c <= 905; c++) begin
            @(negedge clk);
            if (b_mac1_start) begin m1_cnt++; last_a3 = int'(b_address_3); last_a1 = int'(b_address_1); end
            if (b_mac2_start) begin
                m2_cnt++; last_a2 = int'(b_address_2); last_sel = int'(b_sel); last_a6 = int'(b_address_6);
            end
            if (b_busy) busy_cnt++;
            if (b_done) done_cycle = c;
            b_start     = 1'b0;
            b_mac1_done = (c == 786);
            b_sig_ready = (c == 788);
        end
        checks++; if (last_a3 != 783) begin errors++; $display("FAIL def_last_addr3 got=%0d exp=783", last_a3); end
        checks++; if (last_a1 != 783) begin errors++; $display("FAIL def_last_addr1 got=%0d exp=783", last_a1); end
        checks++; if (last_a2 != 99) begin errors++; $display("FAIL def_last_addr2 got=%0d exp=99", last_a2); end
        checks++; if (last_sel != 9) begin errors++; $display("FAIL def_last_sel got=%0d exp=9", last_sel); end
        checks++; if (last_a6 != 9) begin errors++; $display("FAIL def_last_addr6 got=%0d exp=9", last_a6); end
        checks++; if (m1_cnt != 784) begin errors++; $display("FAIL def_mac1_cycles got=%0d exp=784", m1_cnt); end
        checks++; if (m2_cnt != 100) begin errors++; $display("FAIL def_mac2_cycles got=%0d exp=100", m2_cnt); end
        checks++; if (busy_cnt != 896) begin errors++; $display("FAIL def_busy_cycles got=%0d exp=896", busy_cnt); end
        checks++; if (done_cycle != 897) begin errors++; $display("FAIL def_done_cycle got=%0d exp=897", done_cycle); end
    endtask

    initial begin
        test_reset();
        test_inference(1'b0, "inference");
        test_inference(1'b1, "back_to_back");
        test_reset_mid_run();
        test_timeout();
        test_spurious_done();
        test_defaults();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/nn_ctrl.md
NN_CTRL -- requirements
Module: nn_ctrl

Interface
REQ-001 Parameter N_IN, default 784: input-layer length (input SRAM words per inference).
REQ-002 Parameter N_HID, default 10: hidden neurons, one per hidden MAC.
REQ-003 Parameter N_OUT, default 10: output neurons.
REQ-004 Parameter DRAIN, default 8: cycles allowed for the output MAC/sigmoid pipeline to drain.
REQ-005 Parameter TIMEOUT, default 1023: maximum wait cycles for a done/ready input.
REQ-006 Ports:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- start  in  1  begin one inference.
- mac1_done  in  1  hidden-layer MAC done.
- sig_ready  in  1  hidden-layer sigmoids ready.
- address_1  out  18  hidden weight SRAM address.
- address_2  out  12  output weight SRAM address.
- address_3  out  10  input SRAM address.
- address_6  out  7  output register address.
- sel  out  7  hidden-layer mux select.
- mac1_start  out  1  hidden MAC enable.
- mac2_start  out  1  output MAC enable.
- busy  out  1  inference in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  timeout flag.
REQ-007 All outputs SHALL be registered.

Function
REQ-008 States SHALL be IDLE, L1_RUN, L1_WAIT, SIG_WAIT, L2_RUN, L2_DRAIN, FIN, ERR.
REQ-009 IDLE: start=1 SHALL move to L1_RUN next cycle, clear err, and set busy=1; start=0 SHALL hold IDLE.
REQ-010 L1_RUN SHALL last exactly N_IN cycles with mac1_start=1 and address_3=address_1=i, for i = 0..N_IN-1 in cycle order.
REQ-011 address_1 SHALL be i zero-extended to 18 bits, and address_3 SHALL be i truncated to 10 bits.
REQ-012 After i=N_IN-1 the block SHALL enter L1_WAIT with mac1_start=0.
REQ-013 L1_WAIT SHALL move to SIG_WAIT on the first cycle mac1_done=1.
REQ-014 SIG_WAIT SHALL move to L2_RUN on the first cycle sig_ready=1.
REQ-015 L2_RUN SHALL last exactly N_OUT*N_HID cycles with mac2_start=1, using nested counters o (outer, 0..N_OUT-1) and h (inner, 0..N_HID-1).
REQ-016 In each L2_RUN cycle, sel=h, address_6=o, and address_2=o*N_HID+h truncated to 12 bits.
REQ-017 After o=N_OUT-1 and h=N_HID-1 the block SHALL enter L2_DRAIN with mac2_start=0.
REQ-018 L2_DRAIN SHALL last exactly DRAIN cycles, then enter FIN.
REQ-019 FIN SHALL assert done=1 and busy=0 for exactly one cycle, then return to IDLE.
REQ-020 In L1_WAIT and SIG_WAIT a wait counter SHALL increment each cycle; reaching TIMEOUT without the awaited input SHALL force ERR.
REQ-021 ERR SHALL hold err=1, busy=0 and all enables at 0 until start=1, which behaves as in IDLE.
REQ-022 start SHALL be ignored while busy=1.
REQ-023 mac1_done or sig_ready asserted outside its own wait state SHALL be ignored.
REQ-024 Outside its own active state, each address/sel output SHALL hold 0.

Reset
REQ-025 reset=1 at a clock edge SHALL force IDLE, zero all counters, and drive every output to 0 on the next cycle, including mid-inference; reset has priority over start.
REQ-026 The first start after reset release SHALL behave as a fresh inference.

Verification
REQ-027 Use N_IN=4, N_HID=3, N_OUT=2, DRAIN=2. Drive start one cycle with mac1_done and sig_ready each returned 1 cycle after their wait state is entered -> mac1_start high 4 cycles with address_3 0,1,2,3; then mac2_start high 6 cycles with address_2 0..5, sel 0,1,2,0,1,2, address_6 0,0,0,1,1,1; done pulses exactly once, 2 cycles after mac2_start falls.
REQ-028 Pulse start again during L2_RUN -> sequence is unchanged and exactly one done pulse results.
REQ-029 Assert reset during L1_RUN at i=2 -> next cycle all outputs are 0 and the block is idle; a new start restarts at address_3=0.
REQ-030 Set TIMEOUT=5 and hold mac1_done=0 -> err=1 and busy=0 after 5 cycles in L1_WAIT with no mac2_start; a following start clears err.
REQ-031 Pulse mac1_done during L1_RUN and deassert it before L1_WAIT -> the block stays in L1_WAIT until a new mac1_done pulse.
REQ-032 Run defaults N_IN=784, N_HID=10, N_OUT=10 -> last address_3=783, last address_2=99, and busy high for 784+100+8 cycles plus the wait cycles.
